// File: rtl/bsg_mem_sched_pkg.sv
// Shared types for the 2R1W scheduled memory: the response record (v, id, data)
// and the safe clog2 helper. Response data fields are sized for up to 64 bits.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

package bsg_mem_sched_pkg;

    localparam int sched_id_max_width_lp   = 4;
    localparam int sched_data_max_width_lp = 64;

    typedef struct packed {
        logic                               v;
        logic [sched_id_max_width_lp-1:0]   id;
        logic [sched_data_max_width_lp-1:0] data;
    } sched_resp_s;

endpackage

// File: rtl/bsg_mem_2r1w_sync.sv
// Two-read one-write memory with registered (synchronous) read data.
// A read that hits the word being written is skipped unless read_write_same_addr_p is set.
module bsg_mem_2r1w_sync #(
    parameter int width_p                = -1,
    parameter int els_p                  = -1,
    parameter int read_write_same_addr_p = 0,
    localparam int addr_width_lp         = `BSG_SAFE_CLOG2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic                     r0_v_i,
    input  logic [addr_width_lp-1:0] r0_addr_i,
    output logic [width_p-1:0]       r0_data_o,
    input  logic                     r1_v_i,
    input  logic [addr_width_lp-1:0] r1_addr_i,
    output logic [width_p-1:0]       r1_data_o
);

    localparam bit rw_same_lp = (read_write_same_addr_p != 0);

    logic [width_p-1:0] r_mem [0:els_p-1];
    logic [width_p-1:0] r_r0_data;
    logic [width_p-1:0] r_r1_data;
    logic               w_r0_en;
    logic               w_r1_en;

    assign w_r0_en = r0_v_i && (rw_same_lp || !(w_v_i && (w_addr_i == r0_addr_i)));
    assign w_r1_en = r1_v_i && (rw_same_lp || !(w_v_i && (w_addr_i == r1_addr_i)));

    // Colliding reads see the old word; the scheduler decides what to return.
    always_ff @(posedge clk_i) begin
        if (w_v_i)
            r_mem[w_addr_i] <= w_data_i;
        if (w_r0_en)
            r_r0_data <= r_mem[r0_addr_i];
        if (w_r1_en)
            r_r1_data <= r_mem[r1_addr_i];
    end

    assign r0_data_o = r_r0_data;
    assign r1_data_o = r_r1_data;

endmodule

// File: rtl/bsg_mem_2r1w_sync_sched.sv
// Round-robin sharing of the two read ports of a 2R1W sync memory among num_req_p requesters.
// Define BSG_MEM_2R1W_SYNC_SCHED_BYPASS_EN to forward same-cycle write data to colliding reads.
module bsg_mem_2r1w_sync_sched
    import bsg_mem_sched_pkg::*;
#(
    parameter int width_p                = -1,
    parameter int els_p                  = -1,
    parameter int num_req_p              = 4,
    parameter int read_write_same_addr_p = 0,
    localparam int addr_width_lp         = `BSG_SAFE_CLOG2(els_p),
    localparam int id_width_lp           = `BSG_SAFE_CLOG2(num_req_p)
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               w_v_i,
    input  logic [addr_width_lp-1:0]           w_addr_i,
    input  logic [width_p-1:0]                 w_data_i,
    input  logic [num_req_p-1:0]               req_v_i,
    input  logic [num_req_p*addr_width_lp-1:0] req_addr_i,
    output logic [num_req_p-1:0]               req_yumi_o,
    output logic                               resp0_v_o,
    output logic [id_width_lp-1:0]             resp0_id_o,
    output logic [width_p-1:0]                 resp0_data_o,
    output logic                               resp1_v_o,
    output logic [id_width_lp-1:0]             resp1_id_o,
    output logic [width_p-1:0]                 resp1_data_o
);

`ifdef BSG_MEM_2R1W_SYNC_SCHED_BYPASS_EN
    localparam bit bypass_en_lp = 1'b1;
`else
    localparam bit bypass_en_lp = 1'b0;
`endif
    localparam int mem_rw_same_lp   = bypass_en_lp ? 1 : read_write_same_addr_p;
    localparam bit block_collide_lp = !bypass_en_lp && (read_write_same_addr_p == 0);

    logic                     w_wr_v;
    logic [num_req_p-1:0]     w_collide;
    logic [num_req_p-1:0]     w_elig;
    int                       w_scan_idx;
    logic [id_width_lp-1:0]   w_scan_id;
    logic                     w_g0_v;
    logic                     w_g1_v;
    logic [id_width_lp-1:0]   w_g0_id;
    logic [id_width_lp-1:0]   w_g1_id;
    logic [id_width_lp-1:0]   w_last_id;
    logic [id_width_lp-1:0]   w_rr_next;
    logic [num_req_p-1:0]     w_yumi;
    logic [addr_width_lp-1:0] w_r0_addr;
    logic [addr_width_lp-1:0] w_r1_addr;
    logic [width_p-1:0]       w_mem_r0_data;
    logic [width_p-1:0]       w_mem_r1_data;
    logic [width_p-1:0]       w_resp0_data;
    logic [width_p-1:0]       w_resp1_data;

    logic [id_width_lp-1:0]   r_rr_ptr;
    logic                     r_resp0_v;
    logic                     r_resp1_v;
    logic [id_width_lp-1:0]   r_resp0_id;
    logic [id_width_lp-1:0]   r_resp1_id;

    assign w_wr_v = w_v_i && !reset_i;

    always_comb begin
        w_collide = '0;
        w_elig    = '0;
        for (int i = 0; i < num_req_p; i++) begin
            w_collide[i] = w_wr_v && (req_addr_i[i*addr_width_lp +: addr_width_lp] == w_addr_i);
            w_elig[i]    = req_v_i[i] && !reset_i && !(block_collide_lp && w_collide[i]);
        end
    end

    // Scan from the round-robin pointer with wrap; first two eligible win.
    always_comb begin
        w_scan_idx = 0;
        w_scan_id  = '0;
        w_g0_v     = 1'b0;
        w_g1_v     = 1'b0;
        w_g0_id    = '0;
        w_g1_id    = '0;
        w_yumi     = '0;
        for (int k = 0; k < num_req_p; k++) begin
            w_scan_idx = int'(r_rr_ptr) + k;
            if (w_scan_idx >= num_req_p)
                w_scan_idx = w_scan_idx - num_req_p;
            w_scan_id = id_width_lp'(w_scan_idx);
            if (w_elig[w_scan_id]) begin
                if (!w_g0_v) begin
                    w_g0_v  = 1'b1;
                    w_g0_id = w_scan_id;
                end else if (!w_g1_v) begin
                    w_g1_v  = 1'b1;
                    w_g1_id = w_scan_id;
                end
            end
        end
        if (w_g0_v)
            w_yumi[w_g0_id] = 1'b1;
        if (w_g1_v)
            w_yumi[w_g1_id] = 1'b1;
    end

    assign w_last_id  = w_g1_v ? w_g1_id : w_g0_id;
    assign w_rr_next  = (w_last_id == id_width_lp'(num_req_p - 1)) ? '0 : w_last_id + 1'b1;
    assign req_yumi_o = w_yumi;
    assign w_r0_addr  = req_addr_i[w_g0_id*addr_width_lp +: addr_width_lp];
    assign w_r1_addr  = req_addr_i[w_g1_id*addr_width_lp +: addr_width_lp];

    bsg_mem_2r1w_sync #(
        .width_p               (width_p),
        .els_p                 (els_p),
        .read_write_same_addr_p(mem_rw_same_lp)
    ) mem (
        .clk_i    (clk_i),
        .w_v_i    (w_wr_v),
        .w_addr_i (w_addr_i),
        .w_data_i (w_data_i),
        .r0_v_i   (w_g0_v),
        .r0_addr_i(w_r0_addr),
        .r0_data_o(w_mem_r0_data),
        .r1_v_i   (w_g1_v),
        .r1_addr_i(w_r1_addr),
        .r1_data_o(w_mem_r1_data)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rr_ptr   <= '0;
            r_resp0_v  <= 1'b0;
            r_resp1_v  <= 1'b0;
            r_resp0_id <= '0;
            r_resp1_id <= '0;
        end else begin
            if (w_g0_v)
                r_rr_ptr <= w_rr_next;
            r_resp0_v  <= w_g0_v;
            r_resp1_v  <= w_g1_v;
            r_resp0_id <= w_g0_id;
            r_resp1_id <= w_g1_id;
        end
    end

`ifdef BSG_MEM_2R1W_SYNC_SCHED_BYPASS_EN
    logic               r_byp0;
    logic               r_byp1;
    logic [width_p-1:0] r_byp_data;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_byp0 <= 1'b0;
            r_byp1 <= 1'b0;
        end else begin
            r_byp0 <= w_g0_v && w_collide[w_g0_id];
            r_byp1 <= w_g1_v && w_collide[w_g1_id];
        end
        if (w_wr_v)
            r_byp_data <= w_data_i;
    end

    assign w_resp0_data = r_byp0 ? r_byp_data : w_mem_r0_data;
    assign w_resp1_data = r_byp1 ? r_byp_data : w_mem_r1_data;
`else
    assign w_resp0_data = w_mem_r0_data;
    assign w_resp1_data = w_mem_r1_data;
`endif

    sched_resp_s w_resp0;
    sched_resp_s w_resp1;
    logic        w_unused_resp;

    always_comb begin
        w_resp0                       = '0;
        w_resp0.v                     = r_resp0_v;
        w_resp0.id[id_width_lp-1:0]   = r_resp0_id;
        w_resp0.data[width_p-1:0]     = w_resp0_data;
        w_resp1                       = '0;
        w_resp1.v                     = r_resp1_v;
        w_resp1.id[id_width_lp-1:0]   = r_resp1_id;
        w_resp1.data[width_p-1:0]     = w_resp1_data;
    end

    // Padding bits of the shared record are intentionally dropped.
    assign w_unused_resp = ^{w_resp0, w_resp1};

    assign resp0_v_o    = w_resp0.v;
    assign resp0_id_o   = w_resp0.id[id_width_lp-1:0];
    assign resp0_data_o = w_resp0.data[width_p-1:0];
    assign resp1_v_o    = w_resp1.v;
    assign resp1_id_o   = w_resp1.id[id_width_lp-1:0];
    assign resp1_data_o = w_resp1.data[width_p-1:0];

endmodule

// File: tb/tb_bsg_mem_2r1w_sync_sched.sv
// Directed bench for bsg_mem_2r1w_sync_sched (32x32, 4 requesters); honours
// BSG_MEM_2R1W_SYNC_SCHED_BYPASS_EN for the collision case.
module tb_bsg_mem_2r1w_sync_sched;

    localparam int W  = 32;
    localparam int E  = 32;
    localparam int N  = 4;
    localparam int AW = 5;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          w_v;
    logic [AW-1:0] w_addr;
    logic [W-1:0]  w_data;
    logic [N-1:0]  req_v;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]  yumi;
    logic          r0_v, r1_v;
    logic [IW-1:0] r0_id, r1_id;
    logic [W-1:0]  r0_data, r1_data;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bsg_mem_2r1w_sync_sched #(
        .width_p(W), .els_p(E), .num_req_p(N), .read_write_same_addr_p(0)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .w_v_i       (w_v),
        .w_addr_i    (w_addr),
        .w_data_i    (w_data),
        .req_v_i     (req_v),
        .req_addr_i  (req_addr),
        .req_yumi_o  (yumi),
        .resp0_v_o   (r0_v),
        .resp0_id_o  (r0_id),
        .resp0_data_o(r0_data),
        .resp1_v_o   (r1_v),
        .resp1_id_o  (r1_id),
        .resp1_data_o(r1_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        req_addr[i*AW +: AW] = a;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_yumi(input string tag, input logic [N-1:0] exp);
        #1;
        chk(tag, 64'(yumi), 64'(exp));
    endtask

    task automatic chk_resp(input string tag, input bit v0, input int id0, input logic [W-1:0] d0,
                            input bit v1, input int id1, input logic [W-1:0] d1);
        chk({tag, " r0_v"}, 64'(r0_v), 64'(v0));
        if (v0) begin
            chk({tag, " r0_id"}, 64'(r0_id), 64'(id0));
            chk({tag, " r0_data"}, 64'(r0_data), 64'(d0));
        end
        chk({tag, " r1_v"}, 64'(r1_v), 64'(v1));
        if (v1) begin
            chk({tag, " r1_id"}, 64'(r1_id), 64'(id1));
            chk({tag, " r1_data"}, 64'(r1_data), 64'(d1));
        end
    endtask

    initial begin
        reset    = 1'b1;
        w_v      = 1'b1;
        w_addr   = 5'd3;
        w_data   = 32'h0BAD_0BAD;
        req_v    = 4'hF;
        req_addr = '0;
        #2;
        chk_yumi("reset yumi a", 4'b0000);
        cyc();
        chk_yumi("reset yumi b", 4'b0000);
        cyc();
        chk("reset r0_v", 64'(r0_v), 64'd0);
        chk("reset r1_v", 64'(r1_v), 64'd0);
        chk("reset r0_id", 64'(r0_id), 64'd0);
        chk("reset r1_id", 64'(r1_id), 64'd0);

        reset = 1'b0;
        req_v = '0;
        for (int a = 0; a < 16; a++) begin
            w_v    = 1'b1;
            w_addr = AW'(a);
            w_data = 32'hA000_0000 + 32'(a);
            cyc();
        end
        w_addr = 5'd5;
        w_data = 32'hDEAD_BEEF;
        cyc();
        w_v = 1'b0;
        chk_resp("idle", 0, 0, '0, 0, 0, '0);

        // single requester: port 0 only
        req_v = 4'b0100;
        set_addr(2, 5'd5);
        chk_yumi("single yumi", 4'b0100);
        cyc();
        chk_resp("single", 1, 2, 32'hDEAD_BEEF, 0, 0, '0);

        // rr_ptr=3: wrap-around grant order 3 then 0
        req_v = 4'b1001;
        set_addr(3, 5'd3);
        set_addr(0, 5'd0);
        chk_yumi("wrap yumi", 4'b1001);
        cyc();
        chk_resp("wrap", 1, 3, 32'hA000_0003, 1, 0, 32'hA000_0000);

        // rr_ptr now 1: requester 1 ahead of 0
        req_v = 4'b0011;
        set_addr(0, 5'd10);
        set_addr(1, 5'd11);
        chk_yumi("rr1 yumi", 4'b0011);
        cyc();
        chk_resp("rr1", 1, 1, 32'hA000_000B, 1, 0, 32'hA000_000A);

        req_v = 4'b1000;
        set_addr(3, 5'd6);
        chk_yumi("to rr0 yumi", 4'b1000);
        cyc();
        chk_resp("to rr0", 1, 3, 32'hA000_0006, 0, 0, '0);

        // all four requesting from rr_ptr=0
        req_v = 4'hF;
        for (int i = 0; i < N; i++) set_addr(i, AW'(i + 8));
        chk_yumi("all4 yumi a", 4'b0011);
        cyc();
        chk_resp("all4 a", 1, 0, 32'hA000_0008, 1, 1, 32'hA000_0009);
        chk_yumi("all4 yumi b", 4'b1100);
        cyc();
        chk_resp("all4 b", 1, 2, 32'hA000_000A, 1, 3, 32'hA000_000B);
        chk_yumi("all4 yumi c", 4'b0011);
        cyc();
        chk_resp("all4 c", 1, 0, 32'hA000_0008, 1, 1, 32'hA000_0009);

        // read/write collision on address 7, rr_ptr=2
        w_v    = 1'b1;
        w_addr = 5'd7;
        w_data = 32'h0000_1234;
        req_v  = 4'b0011;
        set_addr(0, 5'd7);
        set_addr(1, 5'd9);
`ifdef BSG_MEM_2R1W_SYNC_SCHED_BYPASS_EN
        chk_yumi("collide yumi", 4'b0011);
        cyc();
        chk_resp("collide", 1, 0, 32'h0000_1234, 1, 1, 32'hA000_0009);
`else
        chk_yumi("collide yumi", 4'b0010);
        cyc();
        chk_resp("collide", 1, 1, 32'hA000_0009, 0, 0, '0);
`endif
        w_v   = 1'b0;
        req_v = 4'b0001;
        chk_yumi("after collide yumi", 4'b0001);
        cyc();
        chk_resp("after collide", 1, 0, 32'h0000_1234, 0, 0, '0);

        // reset right after a two-grant cycle; rr_ptr=1 here
        req_v = 4'hF;
        for (int i = 0; i < N; i++) set_addr(i, AW'(i + 8));
        chk_yumi("pre-reset yumi", 4'b0110);
        cyc();
        chk_resp("pre-reset", 1, 1, 32'hA000_0009, 1, 2, 32'hA000_000A);
        reset  = 1'b1;
        w_v    = 1'b1;
        w_addr = 5'd4;
        w_data = 32'h0BAD_F00D;
        chk_yumi("in-reset yumi", 4'b0000);
        cyc();
        chk("post-reset r0_v", 64'(r0_v), 64'd0);
        chk("post-reset r1_v", 64'(r1_v), 64'd0);
        chk("post-reset r0_id", 64'(r0_id), 64'd0);
        chk("post-reset r1_id", 64'(r1_id), 64'd0);
        reset = 1'b0;
        w_v   = 1'b0;
        set_addr(0, 5'd4);
        chk_yumi("post-reset yumi", 4'b0011);
        cyc();
        chk_resp("post-reset", 1, 0, 32'hA000_0004, 1, 1, 32'hA000_0009);

        req_v = '0;
        cyc();
        chk_resp("final idle", 0, 0, '0, 0, 0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
